booth_divider: RTL
==================

// Module: booth_divider
// PURPOSE
//  Sequential signed divider that inverts the radix-4 Booth multiplier datapath.
//  It takes a 2*WIDTH-bit signed dividend (a multiplier product) and a WIDTH-bit signed divisor.
//  It returns a WIDTH-bit signed quotient and remainder.
//  Two restoring quotient bits are retired per clock, the radix-4 counterpart of the multiplier.
//  Valid/ready handshakes are used on both sides.
// PARAMETERS
//  WIDTH   8   divisor/quotient/remainder width; must be even; dividend is 2*WIDTH
// PORTS
//  clk_i        in   1        clock, all state updates on rising edge
//  rst_i        in   1        synchronous reset, active-high
//  in_valid_i   in   1        operands valid
//  in_ready_o   out  1        divider idle, operands accepted this cycle if in_valid_i
//  dividend_i   in   2*WIDTH  signed dividend
//  divisor_i    in   WIDTH    signed divisor
//  out_valid_o  out  1        result valid, held until out_ready_i
//  out_ready_i  in   1        consumer accepts result
//  quotient_o   out  WIDTH    signed quotient, truncated toward zero
//  remainder_o  out  WIDTH    signed remainder, sign of dividend
//  ovf_o        out  1        true quotient outside signed WIDTH range (includes div-by-zero)
//  div0_o       out  1        divisor was zero
// BEHAVIOUR
//  - Reset: state IDLE; in_ready_o=1; out_valid_o=0.
//    quotient_o, remainder_o, ovf_o, div0_o are all 0. Reset wins over every other event, in any state.
//  - FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE: in_ready_o=1. On in_valid_i, latch the operand signs and |dividend| (2*WIDTH bits, unsigned).
//    Also latch |divisor| (WIDTH bits, unsigned) and clear the partial remainder.
//    Divisor==0: skip CALC and go to FIX with div0 set; otherwise go to CALC with step counter = 0.
//  - CALC: exactly WIDTH cycles; each cycle performs two restoring steps.
//    Each step: shift {rem, quot} left 1 and trial-subtract |divisor|. If no borrow, keep the difference and set quot LSB=1.
//    The partial remainder is WIDTH+1 bits so the trial subtraction cannot overflow. Counter wraps to FIX after count WIDTH-1.
//  - FIX: one cycle.
//    q = neg(quot) if sign(dividend)^sign(divisor), else quot.
//    r = neg(rem) if sign(dividend), else rem.
//    ovf = unsigned quot > 2^(WIDTH-1)-1 (same sign) or > 2^(WIDTH-1) (opposite sign).
//    quotient_o = low WIDTH bits of q (also when ovf); remainder_o = r. Register all outputs; go to DONE.
//  - Divide-by-zero FIX: quotient_o=0, remainder_o=dividend_i[WIDTH-1:0], ovf_o=1, div0_o=1.
//  - DONE: out_valid_o=1; quotient_o/remainder_o/ovf_o/div0_o are stable until out_valid_o&&out_ready_i.
//    That handshake returns to IDLE next cycle. out_valid_o is 0 in the cycle after acceptance.
//  - in_ready_o=1 only in IDLE. No overlap: a new operation cannot be accepted in the same cycle a result is accepted.
//  - Latency, acceptance edge to out_valid_o: WIDTH+2 cycles (10 for WIDTH=8); 2 cycles for divide-by-zero.
//    Throughput: one result per WIDTH+3 cycles with out_ready_i held high.
//  - Inputs are sampled only on the acceptance edge; later changes on dividend_i/divisor_i are ignored.
//  - Edge cases: most-negative dividend magnitude 2^(2*WIDTH-1) fits the unsigned register.
//    Most-negative divisor magnitude 2^(WIDTH-1) fits WIDTH unsigned bits.
// STRUCTURE
//  - Package div_pkg: state enum (IDLE, CALC, FIX, DONE); DIV_WIDTH default constant 8.
//  - Sub-module div_step2 (combinational): inputs rem, quot, |divisor|; outputs rem, quot after two restoring steps.
//    Instantiated once in booth_divider. The rest (FSM, counter, sign fix-up, handshake regs) stays in booth_divider.
// TESTING
//  1. 100 / 7 -> q=14 (0x0E), r=2, ovf=0; out_valid_o exactly 10 cycles after accept.
//  2. -100 / 7 -> q=-14 (0xF2), r=-2 (0xFE); 100 / -7 -> q=0xF2, r=2.
//  3. 1000 / 7 -> ovf_o=1, q=0x8E (low bits of 142), r=6.
//     -1024 / 8 -> q=0x80, r=0, ovf_o=0 (boundary, no overflow).
//  4. 1234 / 0 -> div0_o=1, ovf_o=1, q=0, r=0xD2; out_valid_o 2 cycles after accept.
//  5. Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> outputs stable, in_ready_o=0.
//     Release -> IDLE next cycle, in_ready_o=1.
//  6. Reset asserted mid-CALC -> next cycle IDLE, all outputs 0.
//     Round trip: feed every 8x8 booth multiplier product with nonzero MR as dividend, MR as divisor -> q=MD, r=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the radix-4 restoring divider: FSM states and default width.
package div_pkg;
  localparam int DIV_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
endpackage

// File: rtl/div_step2.sv
// Two restoring division steps on {rem, quot}; purely combinational.
// A step keeps the trial difference only when it does not borrow (rem >= divisor).
module div_step2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]     rem_i,
  input  logic [2*WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0]   dvs_i,
  output logic [WIDTH:0]     rem_o,
  output logic [2*WIDTH-1:0] quot_o
);
  logic [WIDTH+1:0]   dvs_x;
  logic [WIDTH+1:0]   sh0;
  logic [WIDTH+1:0]   sh1;
  logic [WIDTH:0]     rem_mid;
  logic [2*WIDTH-1:0] quot_mid;
  logic               ge0;
  logic               ge1;

  always_comb begin
    dvs_x    = {2'b00, dvs_i};
    sh0      = {rem_i, quot_i[2*WIDTH-1]};
    ge0      = sh0 >= dvs_x;
    rem_mid  = ge0 ? (WIDTH+1)'(sh0 - dvs_x) : sh0[WIDTH:0];
    quot_mid = {quot_i[2*WIDTH-2:0], ge0};
    sh1      = {rem_mid, quot_mid[2*WIDTH-1]};
    ge1      = sh1 >= dvs_x;
    rem_o    = ge1 ? (WIDTH+1)'(sh1 - dvs_x) : sh1[WIDTH:0];
    quot_o   = {quot_mid[2*WIDTH-2:0], ge1};
  end
endmodule

// File: rtl/booth_divider.sv
// Signed 2W/W sequential divider, two quotient bits per clock; result after WIDTH+2 edges
// (2 on divide-by-zero); result held in DONE until out_ready_i, no new operand until then.
module booth_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2*WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     quotient_o,
  output logic [WIDTH-1:0]     remainder_o,
  output logic                 ovf_o,
  output logic                 div0_o
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] QMAX_POS = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] QMAX_NEG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  state_e               state_q;
  logic [CW-1:0]        step_q;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [2*WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]     dvs_q;
  logic                 sgn_n_q, sgn_d_q, zero_q;
  logic                 in_ready_q, out_valid_q, ovf_q, div0_q;
  logic [WIDTH-1:0]     quotient_q, remainder_q;

  logic [2*WIDTH-1:0]   dividend_abs;
  logic [WIDTH-1:0]     divisor_abs, q_lo, q_fix, r_fix, n_fix;
  logic                 ovf_fix;

  div_step2 #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvs_i  (dvs_q),
    .rem_o  (rem_d),
    .quot_o (quot_d)
  );

  always_comb begin
    dividend_abs = dividend_i[2*WIDTH-1] ? -dividend_i : dividend_i;
    divisor_abs  = divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
    q_lo    = quot_q[WIDTH-1:0];
    q_fix   = (sgn_n_q ^ sgn_d_q) ? -q_lo : q_lo;
    r_fix   = sgn_n_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    // On divide-by-zero quot_q still holds |dividend|; re-sign it to recover the raw low bits.
    n_fix   = sgn_n_q ? -q_lo : q_lo;
    ovf_fix = quot_q > ((sgn_n_q ^ sgn_d_q) ? QMAX_NEG : QMAX_POS);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      step_q      <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dvs_q       <= '0;
      sgn_n_q     <= 1'b0;
      sgn_d_q     <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            sgn_n_q    <= dividend_i[2*WIDTH-1];
            sgn_d_q    <= divisor_i[WIDTH-1];
            quot_q     <= dividend_abs;
            dvs_q      <= divisor_abs;
            rem_q      <= '0;
            step_q     <= '0;
            zero_q     <= (divisor_i == '0);
            in_ready_q <= 1'b0;
            state_q    <= (divisor_i == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          step_q <= step_q + CW'(1);
          if (step_q == LAST) state_q <= FIX;
        end
        FIX: begin
          quotient_q  <= zero_q ? '0 : q_fix;
          remainder_q <= zero_q ? n_fix : r_fix;
          ovf_q       <= zero_q | ovf_fix;
          div0_q      <= zero_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign ovf_o       = ovf_q;
  assign div0_o      = div0_q;
endmodule
